mult_operand_sequencer: RTL and testbench

Upstream front-end for the sequential Booth multiplier (Start/Ready/word1/word2/product interface). It buffers signed operand pairs from a valid/ready source in a 2-entry FIFO and issues each pair to the multiplier with a one-cycle Start pulse. It waits for Ready, then returns the product through a valid/ready result port. A watchdog flags a multiplier that never acknowledges or never completes.

---
 rtl/mult_operand_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_mult_operand_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_operand_sequencer.sv
// mult_operand_sequencer
// ----------------------
// Front-end for a sequential Booth multiplier that uses a Start/Ready
// interface. Signed operand pairs arrive on a valid/ready input port and are
// buffered in a 2-entry FIFO. Each pair is issued to the multiplier with a
// one-cycle Start pulse. The block then waits for Ready and returns the
// product on a valid/ready result port. A watchdog turns a multiplier that
// never acknowledges, or never completes, into an error result.
//
// Handshake rule (both streams): a transfer happens on a rising clock edge
// where valid && ready. A producer holds valid and its payload stable until
// that edge. ready may depend combinationally on state, but not on valid.
//
// Ports:
//   clock, reset          clock; asynchronous active-low reset
//   in_valid/in_ready     operand stream; in_word1, in_word2 are signed
//   out_valid/out_ready   result stream; out_product and out_error are
//                         qualified by out_valid
//   mult_word1/2          operands to the multiplier, held for the whole multiply
//   mult_start            one-cycle Start pulse to the multiplier
//   mult_ready            Ready from the multiplier
//   mult_product          product from the multiplier
//   busy                  high while an operation is in flight or queued
//   op_count              number of completed result transfers (wraps)
//   dbg_state             current FSM state, for debug and checkers
module mult_operand_sequencer #(
    parameter int L_word  = 4,
    parameter int TIMEOUT = 15,
    parameter int L_TO    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [L_word-1:0]     in_word1,
    input  logic [L_word-1:0]     in_word2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*L_word-1:0]   out_product,
    output logic                  out_error,
    output logic [L_word-1:0]     mult_word1,
    output logic [L_word-1:0]     mult_word2,
    output logic                  mult_start,
    input  logic                  mult_ready,
    input  logic [2*L_word-1:0]   mult_product,
    output logic                  busy,
    output logic [7:0]            op_count,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ACK   = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    localparam logic [L_TO-1:0] TO_VAL = L_TO'(TIMEOUT);

    state_t                state_q, state_d;
    logic [L_TO-1:0]       wd_q, wd_d;

    logic [L_word-1:0]     fifo_w1_q [2];
    logic [L_word-1:0]     fifo_w2_q [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            count_q;

    logic [L_word-1:0]     mult_word1_q, mult_word2_q;
    logic                  out_valid_q, out_error_q;
    logic [2*L_word-1:0]   out_product_q;
    logic [7:0]            op_count_q;

    logic                  fifo_full, fifo_empty;
    logic                  push, pop;
    logic                  out_hs, slot_free;
    logic                  res_wr, res_err;
    logic [2*L_word-1:0]   res_prod;

    assign fifo_full  = (count_q == 2'd2);
    assign fifo_empty = (count_q == 2'd0);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;

    // The result slot can take a new result when it is empty, or when its
    // current result is being consumed in this same cycle.
    assign out_hs     = out_valid_q && out_ready;
    assign slot_free  = !out_valid_q || out_ready;

    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        pop      = 1'b0;
        res_wr   = 1'b0;
        res_err  = 1'b0;
        res_prod = '0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && slot_free) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_ACK;
            S_ACK: begin
                // Ready still high here means the multiplier never left its
                // done state, so the Start pulse was not taken.
                if (mult_ready) begin
                    res_wr  = 1'b1;
                    res_err = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d    = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wd_d = wd_q + 1'b1;
                // Completion takes priority over the watchdog.
                if (mult_ready) begin
                    res_wr   = 1'b1;
                    res_prod = mult_product;
                    state_d  = S_IDLE;
                end else if (wd_q == TO_VAL) begin
                    res_wr  = 1'b1;
                    res_err = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifo_w1_q[0] <= '0;
            fifo_w1_q[1] <= '0;
            fifo_w2_q[0] <= '0;
            fifo_w2_q[1] <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            if (push) begin
                fifo_w1_q[wr_ptr_q] <= in_word1;
                fifo_w2_q[wr_ptr_q] <= in_word2;
                wr_ptr_q            <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            if (push && !pop) begin
                count_q <= count_q + 2'd1;
            end else if (!push && pop) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

    // Operand registers change only on a pop, so the multiplier sees stable
    // words from the Start pulse until the next pair is issued.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mult_word1_q <= '0;
            mult_word2_q <= '0;
        end else if (pop) begin
            mult_word1_q <= fifo_w1_q[rd_ptr_q];
            mult_word2_q <= fifo_w2_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q   <= 1'b0;
            out_error_q   <= 1'b0;
            out_product_q <= '0;
            op_count_q    <= 8'd0;
        end else begin
            if (res_wr) begin
                out_valid_q   <= 1'b1;
                out_error_q   <= res_err;
                out_product_q <= res_prod;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
            if (out_hs) begin
                op_count_q <= op_count_q + 8'd1;
            end
        end
    end

    assign mult_start  = (state_q == S_ISSUE);
    assign mult_word1  = mult_word1_q;
    assign mult_word2  = mult_word2_q;
    assign out_valid   = out_valid_q;
    assign out_error   = out_error_q;
    assign out_product = out_product_q;
    assign op_count    = op_count_q;
    assign busy        = (state_q != S_IDLE) || !fifo_empty;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
module tb_mult_operand_sequencer;

    localparam int L       = 4;
    localparam int P       = 2 * L;
    localparam int TIMEOUT = 15;
    localparam int M_NORMAL = 0;
    localparam int M_HANG   = 1;
    localparam int M_STUCK  = 2;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [L-1:0] in_word1 = '0;
    logic [L-1:0] in_word2 = '0;
    logic         out_valid;
    logic         out_ready;
    logic [P-1:0] out_product;
    logic         out_error;
    logic [L-1:0] mult_word1, mult_word2;
    logic         mult_start;
    logic         mult_ready;
    logic [P-1:0] mult_product;
    logic         busy;
    logic [7:0]   op_count;
    logic [1:0]   dbg_state;

    logic rand_rdy  = 1'b0;
    logic rdy_fixed = 1'b1;
    logic rnd_bit   = 1'b0;
    assign out_ready = rand_rdy ? rnd_bit : rdy_fixed;

    always @(posedge clock) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    mult_operand_sequencer #(.L_word(L), .TIMEOUT(TIMEOUT), .L_TO(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word1     (in_word1),
        .in_word2     (in_word2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .out_error    (out_error),
        .mult_word1   (mult_word1),
        .mult_word2   (mult_word2),
        .mult_start   (mult_start),
        .mult_ready   (mult_ready),
        .mult_product (mult_product),
        .busy         (busy),
        .op_count     (op_count),
        .dbg_state    (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [P-1:0] smul(input logic [L-1:0] a, input logic [L-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[P-1:0];
    endfunction

    // Multiplier stand-in: Ready high when idle/done, drops the cycle after
    // Start, rises again with the product after a random delay.
    int           mode = M_NORMAL;
    logic         m_busy;
    logic [2:0]   m_cnt;
    logic [L-1:0] m_a, m_b;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy       <= 1'b0;
            m_cnt        <= '0;
            m_a          <= '0;
            m_b          <= '0;
            mult_ready   <= 1'b1;
            mult_product <= '0;
        end else if (mode == M_STUCK) begin
            mult_ready <= 1'b1;
        end else if (mult_start) begin
            mult_ready <= 1'b0;
            m_busy     <= 1'b1;
            m_cnt      <= 3'($urandom_range(0, 5));
            m_a        <= mult_word1;
            m_b        <= mult_word2;
        end else if (m_busy && mode == M_NORMAL) begin
            if (m_cnt == 3'd0) begin
                mult_ready   <= 1'b1;
                mult_product <= smul(m_a, m_b);
                m_busy       <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 3'd1;
            end
        end
    end

    // scoreboard: expected result {error, product} per accepted pair, in order
    logic [P:0]     exp_q[$];
    logic [2*L-1:0] iss_q[$];
    logic [P-1:0]   got_q[$];
    int   n_hs     = 0;
    int   n_starts = 0;
    logic prev_start = 1'b0;
    logic held_v = 1'b0;
    logic [P:0] held_r = '0;

    function automatic logic [P:0] expected_of(input logic [L-1:0] a, input logic [L-1:0] b);
        if (mode == M_NORMAL) return {1'b0, smul(a, b)};
        return {1'b1, {P{1'b0}}};
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(expected_of(in_word1, in_word2));
                iss_q.push_back({in_word1, in_word2});
            end
            if (mult_start) begin
                check("start_one_cycle", 32'(prev_start), 0);
                if (iss_q.size() == 0) begin
                    check("start_unexpected", 1, 0);
                end else begin
                    logic [2*L-1:0] op;
                    op = iss_q.pop_front();
                    check("mult_word1", 32'(mult_word1), 32'(op[2*L-1:L]));
                    check("mult_word2", 32'(mult_word2), 32'(op[L-1:0]));
                end
                n_starts++;
            end
            if (held_v) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_result", 32'({out_error, out_product}), 32'(held_r));
            end
            held_v = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        logic [P:0] e;
                        e = exp_q.pop_front();
                        check("result", 32'({out_error, out_product}), 32'(e));
                    end
                    check("op_count", 32'(op_count), 32'(n_hs[7:0]));
                    n_hs++;
                    got_q.push_back(out_product);
                end else begin
                    held_v = 1'b1;
                    held_r = {out_error, out_product};
                end
            end
            prev_start = mult_start;
        end else begin
            prev_start = 1'b0;
            held_v     = 1'b0;
        end
    end

    // driver tasks
    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [L-1:0] a, input logic [L-1:0] b);
        logic ok;
        int   n;
        in_valid = 1'b1;
        in_word1 = a;
        in_word2 = b;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 500) begin
            @(negedge clock);
            ok = in_ready;
            @(posedge clock);
            #1;
            n++;
        end
        if (!ok) check("push_accept", 32'(ok), 1);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            sync();
            done = (exp_q.size() == 0) && !busy && !out_valid;
            n++;
        end
        check("drain", 32'(done), 1);
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!mult_start && n < 300);
        check("start_seen", 32'(mult_start), 1);
    endtask

    task automatic cycles_to_valid(output int c);
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!out_valid && c < 200);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, s;
        // reset state
        repeat (3) @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_error", 32'(out_error), 0);
        check("rst_out_product", 32'(out_product), 0);
        check("rst_mult_words", 32'({mult_word1, mult_word2}), 0);
        check("rst_mult_start", 32'(mult_start), 0);
        check("rst_op_count", 32'(op_count), 0);
        check("rst_busy", 32'(busy), 0);
        sync();
        reset = 1'b1;
        sync();

        // 1: single pair 3 * 5
        push(4'h3, 4'h5);
        idle_in();
        wait_start();
        check("t1_word1", 32'(mult_word1), 32'h3);
        check("t1_word2", 32'(mult_word2), 32'h5);
        @(negedge clock);
        check("t1_start_drop", 32'(mult_start), 0);
        got_q.delete();
        drain();
        check("t1_nres", got_q.size(), 1);
        if (got_q.size() == 1) check("t1_product", 32'(got_q[0]), 32'h0F);
        check("t1_op_count", 32'(op_count), 1);

        // 2: negative operands
        got_q.delete();
        push(4'h8, 4'h7);
        push(4'h8, 4'h8);
        idle_in();
        drain();
        check("t2_nres", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t2_first", 32'(got_q[0]), 32'hC8);
            check("t2_second", 32'(got_q[1]), 32'h40);
        end

        // 3: back-pressure fills the FIFO and blocks issue
        rdy_fixed = 1'b0;
        push(4'h2, 4'h3);
        push(4'hF, 4'h6);
        push(4'h7, 4'h7);
        idle_in();
        @(negedge clock);
        check("t3_in_ready_full", 32'(in_ready), 0);
        repeat (2) @(negedge clock);
        sync();
        s = n_starts;
        repeat (40) @(negedge clock);
        check("t3_result_waiting", 32'(out_valid), 1);
        sync();
        check("t3_no_new_start", n_starts, s);
        rdy_fixed = 1'b1;
        drain();

        // 4: multiplier never completes
        mode = M_HANG;
        push(4'h5, 4'h5);
        idle_in();
        wait_start();
        cycles_to_valid(c);
        check("t4_timeout_latency", c, TIMEOUT + 3);
        check("t4_error", 32'(out_error), 1);
        check("t4_product", 32'(out_product), 0);
        drain();

        // 5: Ready stuck high, start never taken
        mode = M_STUCK;
        sync();
        sync();
        push(4'h6, 4'h2);
        idle_in();
        wait_start();
        cycles_to_valid(c);
        check("t5_ack_latency", c, 2);
        check("t5_error", 32'(out_error), 1);
        drain();
        check("t5_idle", 32'(busy), 0);

        // random traffic with random back-pressure
        mode = M_NORMAL;
        sync();
        sync();
        rand_rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) begin
                idle_in();
                repeat ($urandom_range(1, 3)) sync();
            end
        end
        idle_in();
        rand_rdy  = 1'b0;
        rdy_fixed = 1'b1;
        drain();

        // 6: reset during S_WAIT
        mode = M_HANG;
        push(4'h4, 4'h4);
        idle_in();
        wait_start();
        repeat (5) @(negedge clock);
        sync();
        check("t6_busy_before", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("t6_out_valid", 32'(out_valid), 0);
        check("t6_in_ready", 32'(in_ready), 1);
        check("t6_busy", 32'(busy), 0);
        check("t6_mult_start", 32'(mult_start), 0);
        check("t6_op_count", 32'(op_count), 0);
        exp_q.delete();
        iss_q.delete();
        n_hs = 0;
        mode = M_NORMAL;
        sync();
        sync();
        reset = 1'b1;
        c = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (out_valid) c++;
        end
        check("t6_no_stale_valid", c, 0);
        sync();
        push(4'hD, 4'h3);
        idle_in();
        drain();
        check("t6_op_count_after", 32'(op_count), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
